// File: rtl/cfg_tile_pkg.sv
// cfg_tile_pkg: shared constants and types for the configurable logic tile.
//   - configuration header opcodes
//   - field positions inside a plane-write header (1LLLPP00)
//   - loader FSM state encoding
//   - reset fill pattern of the four LUT planes
package cfg_tile_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_COMMIT = 8'h01;
  localparam logic [7:0] OP_MASK   = 8'h02;
  localparam logic [7:0] OP_CLRERR = 8'h03;

  localparam int HDR_WR_BIT    = 7;
  localparam int HDR_LAYER_LSB = 4;
  localparam int HDR_PLANE_LSB = 2;

  localparam int N_PLANES = 4;

  // Bit p gives the replicated reset value of plane p: P0/P1 clear,
  // P2/P3 set, so every layer starts out passing x straight through.
  localparam logic [3:0] PLANE_RST_FILL = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  function automatic logic is_plane_wr(input logic [7:0] hdr);
    return hdr[HDR_WR_BIT] && (hdr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/lut_layer.sv
// lut_layer: one stage of per-bit 2-input LUTs.
//   clk, rst_n     clock, async active-low reset
//   wr_en          load wr_data into shadow plane wr_plane
//   wr_plane       shadow plane index 0..3
//   wr_data        plane contents
//   commit         copy all shadow planes into the active planes
//   x              layer input
//   y              y[i] = P[{x[i], x[(i+1) mod WIDTH]}][i] (active planes)
module lut_layer
  import cfg_tile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_plane,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] sh_p  [N_PLANES];
  logic [WIDTH-1:0] act_p [N_PLANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_PLANES; p++) begin
        sh_p[p]  <= {WIDTH{PLANE_RST_FILL[p]}};
        act_p[p] <= {WIDTH{PLANE_RST_FILL[p]}};
      end
    end else begin
      if (wr_en) begin
        sh_p[wr_plane] <= wr_data;
      end
      if (commit) begin
        for (int p = 0; p < N_PLANES; p++) begin
          act_p[p] <= sh_p[p];
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = act_p[{x[i], x[(i + 1) % WIDTH]}][i];
  end

endmodule

// File: rtl/cfg_logic_tile.sv
// cfg_logic_tile: reconfigurable logic tile.
//   data_in  -> LAYERS cascaded lut_layer stages -> XOR mask -> data_out (registered)
//   cfg_in / cfg_valid / cfg_ready   byte-wide configuration stream into shadow storage
//   cfg_err                          sticky protocol error, cleared by OP_CLRERR
//   cfg_gen                          number of commits, modulo 16
// PIPELINE=1 adds a register after every layer (latency LAYERS+1).
//
// state  | meaning
// IDLE   | next accepted byte is a header
// DATA   | collecting cnt more data bytes of a plane/mask write
// COMMIT | one dead cycle after a commit, cfg_ready low
module cfg_logic_tile
  import cfg_tile_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LAYERS   = 4,
  parameter int PIPELINE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic [7:0]       cfg_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [3:0]       cfg_gen
);

  localparam int         NB       = (WIDTH + 7) / 8;
  localparam logic [2:0] NB_W     = 3'(NB);
  localparam logic [3:0] LAYERS_W = 4'(LAYERS);

  cfg_state_t state, state_nxt;

  logic [2:0]      cnt;
  logic            tgt_mask;
  logic            tgt_drop;
  logic [2:0]      tgt_layer;
  logic [1:0]      tgt_plane;
  logic [NB*8-1:0] asm_q;
  logic [NB*8-1:0] asm_next;
  logic [2:0]      byte_idx;

  logic            accept;
  logic            hdr_load;
  logic            data_take;
  logic            data_last;
  logic            commit_go;
  logic            err_set;
  logic            err_clr;
  logic            hdr_plane_wr;
  logic [2:0]      hdr_layer;
  logic            layer_bad;

  logic [WIDTH-1:0] mask_sh;
  logic [WIDTH-1:0] mask_act;
  logic [WIDTH-1:0] wr_data;
  logic [LAYERS-1:0] lay_wr;

  assign cfg_ready    = (state != COMMIT);
  assign accept       = cfg_valid && cfg_ready;
  assign hdr_plane_wr = is_plane_wr(cfg_in);
  assign hdr_layer    = cfg_in[HDR_LAYER_LSB +: 3];
  assign layer_bad    = hdr_plane_wr && ({1'b0, hdr_layer} >= LAYERS_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hdr_load  = 1'b0;
    data_take = 1'b0;
    data_last = 1'b0;
    commit_go = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hdr_plane_wr || (cfg_in == OP_MASK)) begin
            hdr_load  = 1'b1;
            err_set   = layer_bad;
            state_nxt = DATA;
          end else if (cfg_in == OP_COMMIT) begin
            commit_go = 1'b1;
            state_nxt = COMMIT;
          end else if (cfg_in == OP_CLRERR) begin
            err_clr = 1'b1;
          end else if (cfg_in != OP_NOP) begin
            err_set = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          data_take = 1'b1;
          if (cnt == 3'd1) begin
            data_last = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian assembly: the byte arriving with count cnt lands at
  // index NB-cnt. The completed word is taken combinationally so the
  // shadow updates on the same edge that accepts the last byte.
  assign byte_idx = (cnt == 3'd0) ? 3'd0 : (NB_W - cnt);

  always_comb begin
    asm_next = asm_q;
    asm_next[8 * int'(byte_idx) +: 8] = cfg_in;
  end

  assign wr_data = asm_next[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 3'd0;
      tgt_mask  <= 1'b0;
      tgt_drop  <= 1'b0;
      tgt_layer <= 3'd0;
      tgt_plane <= 2'd0;
      asm_q     <= '0;
      mask_sh   <= '0;
      mask_act  <= '0;
      cfg_err   <= 1'b0;
      cfg_gen   <= 4'd0;
    end else begin
      if (hdr_load) begin
        cnt       <= NB_W;
        tgt_mask  <= (cfg_in == OP_MASK);
        tgt_drop  <= layer_bad;
        tgt_layer <= hdr_layer;
        tgt_plane <= cfg_in[HDR_PLANE_LSB +: 2];
      end
      if (data_take) begin
        cnt   <= cnt - 3'd1;
        asm_q <= asm_next;
      end
      if (data_last && tgt_mask) begin
        mask_sh <= wr_data;
      end
      if (commit_go) begin
        mask_act <= mask_sh;
        cfg_gen  <= cfg_gen + 4'd1;
      end
      if (err_set) begin
        cfg_err <= 1'b1;
      end else if (err_clr) begin
        cfg_err <= 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] stage_in  [LAYERS+1];
  logic [WIDTH-1:0] stage_out [LAYERS];

  assign stage_in[0] = data_in;

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    assign lay_wr[l] = data_last && !tgt_mask && !tgt_drop && (tgt_layer == 3'(l));

    lut_layer #(.WIDTH(WIDTH)) u_layer (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (lay_wr[l]),
      .wr_plane (tgt_plane),
      .wr_data  (wr_data),
      .commit   (commit_go),
      .x        (stage_in[l]),
      .y        (stage_out[l])
    );

    if (PIPELINE != 0) begin : g_pipe
      logic [WIDTH-1:0] pipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= stage_out[l];
        end
      end
      assign stage_in[l+1] = pipe_q;
    end else begin : g_comb
      assign stage_in[l+1] = stage_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      data_out <= stage_in[LAYERS] ^ mask_act;
    end
  end

endmodule
